// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } div_state_t;

   localparam int unsigned DIV_N = 8;

   // Returns a 64-bit word with the low 'width' bits set.
   function automatic logic [63:0] all_ones(input int unsigned width);
      logic [63:0] v;
      v = '0;
      for (int unsigned i = 0; i < 64; i++) begin
         if (i < width) v[i] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring division step: trial subtract, keep or restore.
module div_restore_step #(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0] r,
   input  logic         q_msb,
   input  logic [N-1:0] d,
   output logic [N-1:0] r_next,
   output logic         q_bit
);

   logic [N:0] t;

   // On restore the shifted value is below D, so its top bit is always zero.
   always_comb begin
      t      = {r, q_msb} - {1'b0, d};
      q_bit  = ~t[N];
      r_next = t[N] ? {r[N-2:0], q_msb} : t[N-1:0];
   end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential radix-2 restoring divider with valid/ready handshakes on both sides.
module seq_restoring_divider
   import div_pkg::*;
#(
   parameter int unsigned N    = DIV_N,
   parameter int unsigned CNTW = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2*N-1:0]   dividend,
   input  logic [N-1:0]     divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*N-1:0]   quotient,
   output logic [N-1:0]     remainder,
   output logic             div_zero
);

   localparam logic [CNTW-1:0]  LAST_CNT = CNTW'(2*N-1);
   localparam logic [2*N-1:0]   Q_ONES   = (2*N)'(all_ones(2*N));

   div_state_t        state, state_next;
   logic [CNTW-1:0]   cnt;
   logic [N-1:0]      r_acc;
   logic [2*N-1:0]    q_acc;
   logic [N-1:0]      d_reg;
   logic              dz_pend;
   logic [N-1:0]      r_next;
   logic              q_bit;

   div_restore_step #(.N(N)) u_step (
      .r      (r_acc),
      .q_msb  (q_acc[2*N-1]),
      .d      (d_reg),
      .r_next (r_next),
      .q_bit  (q_bit)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (in_valid) state_next = (divisor == '0) ? DONE : CALC;
         CALC: if (cnt == '0) state_next = DONE;
         DONE: if (out_valid && out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == IDLE);
   end

   // Both paths finish in q_acc/r_acc; DONE copies them to the outputs one cycle later.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt       <= '0;
         r_acc     <= '0;
         q_acc     <= '0;
         d_reg     <= '0;
         dz_pend   <= 1'b0;
         out_valid <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  d_reg <= divisor;
                  cnt   <= LAST_CNT;
                  if (divisor == '0) begin
                     q_acc   <= Q_ONES;
                     r_acc   <= dividend[N-1:0];
                     dz_pend <= 1'b1;
                  end else begin
                     q_acc   <= dividend;
                     r_acc   <= '0;
                     dz_pend <= 1'b0;
                  end
               end
            end
            CALC: begin
               r_acc <= r_next;
               q_acc <= {q_acc[2*N-2:0], q_bit};
               if (cnt != '0) cnt <= cnt - 1'b1;
            end
            DONE: begin
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  quotient  <= q_acc;
                  remainder <= r_acc;
                  div_zero  <= dz_pend;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench: arithmetic model of division plus hand-computed directed vectors.
module tb_seq_restoring_divider;

   localparam int unsigned N = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [15:0]   dividend = '0;
   logic [7:0]    divisor = '0;
   logic          in_ready, out_valid, div_zero;
   logic [15:0]   quotient;
   logic [7:0]    remainder;

   int            checks = 0;
   int            errors = 0;
   int unsigned   cyc = 0;

   logic [15:0]   exp_q = '0;
   logic [7:0]    exp_r = '0;
   logic          exp_z = 1'b0;
   logic          exp_armed = 1'b0;

   seq_restoring_divider #(.N(N), .CNTW(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Expected result straight from the arithmetic definition of division.
   task automatic model(input logic [15:0] dd, input logic [7:0] dv);
      int unsigned a, b;
      a = dd;
      b = dv;
      if (b == 0) begin
         exp_q = 16'hFFFF;
         exp_r = dd[7:0];
         exp_z = 1'b1;
      end else begin
         exp_q = 16'(a / b);
         exp_r = 8'(a % b);
         exp_z = 1'b0;
      end
   endtask

   // Compare process: every cycle a result is presented it must match the model.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (!exp_armed) begin
            check("spurious_out_valid", {31'd0, exp_armed}, 32'd1);
         end else begin
            check("quotient", {16'd0, quotient}, {16'd0, exp_q});
            check("remainder", {24'd0, remainder}, {24'd0, exp_r});
            check("div_zero", {31'd0, div_zero}, {31'd0, exp_z});
            check("in_ready_while_done", {31'd0, in_ready}, 32'd0);
         end
      end
   end

   task automatic run_div(input logic [15:0] dd, input logic [7:0] dv,
                          input int unsigned hold, input bit pulse,
                          input logic [15:0] lit_q, input logic [7:0] lit_r, input logic lit_z);
      int unsigned n, acc, lat;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check("in_ready_wait", {31'd0, in_ready}, 32'd1);
      dividend = dd;
      divisor  = dv;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      dividend = 16'hA5A5;
      divisor  = 8'h03;
      model(dd, dv);
      exp_armed = 1'b1;
      acc = cyc;
      n = 0;
      while (!out_valid && n < 40) begin
         check("in_ready_busy", {31'd0, in_ready}, 32'd0);
         if (pulse && n == 4) in_valid = 1'b1;
         if (pulse && n == 6) in_valid = 1'b0;
         @(posedge clk); #1; n++;
      end
      in_valid = 1'b0;
      check("out_valid_seen", {31'd0, out_valid}, 32'd1);
      lat = cyc - acc;
      check("latency", lat, (dv == 0) ? 32'd1 : 32'd17);
      check("lit_quotient", {16'd0, quotient}, {16'd0, lit_q});
      check("lit_remainder", {24'd0, remainder}, {24'd0, lit_r});
      check("lit_div_zero", {31'd0, div_zero}, {31'd0, lit_z});
      for (int unsigned i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("held_valid", {31'd0, out_valid}, 32'd1);
         check("held_quotient", {16'd0, quotient}, {16'd0, lit_q});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      exp_armed = 1'b0;
      check("valid_drop", {31'd0, out_valid}, 32'd0);
      check("in_ready_after", {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_quotient", {16'd0, quotient}, 32'd0);
      check("rst_remainder", {24'd0, remainder}, 32'd0);
      check("rst_div_zero", {31'd0, div_zero}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_div(16'd65025, 8'd255, 0, 1'b0, 16'd255,   8'd0,  1'b0);
      run_div(16'd100,   8'd7,   0, 1'b0, 16'd14,    8'd2,  1'b0);
      run_div(16'd65535, 8'd1,   0, 1'b0, 16'd65535, 8'd0,  1'b0);
      run_div(16'h1234,  8'd0,   0, 1'b0, 16'hFFFF,  8'h34, 1'b1);
      run_div(16'd12345, 8'd100, 5, 1'b0, 16'd123,   8'd45, 1'b0);
      run_div(16'd1000,  8'd3,   0, 1'b1, 16'd333,   8'd1,  1'b0);
      run_div(16'd0,     8'd5,   0, 1'b0, 16'd0,     8'd0,  1'b0);
      run_div(16'd255,   8'd255, 0, 1'b0, 16'd1,     8'd0,  1'b0);
      run_div(16'd65535, 8'd255, 2, 1'b0, 16'd257,   8'd0,  1'b0);
      run_div(16'd7,     8'd9,   0, 1'b0, 16'd0,     8'd7,  1'b0);

      // Reset in the middle of a division; the aborted result must never appear.
      dividend = 16'd5000;
      divisor  = 8'd7;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
      end
      check("busy_before_reset", {31'd0, in_ready}, 32'd0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("abort_in_ready", {31'd0, in_ready}, 32'd1);
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      repeat (20) begin
         @(posedge clk); #1;
      end
      check("abort_still_idle", {31'd0, out_valid}, 32'd0);
      run_div(16'd200, 8'd13, 0, 1'b0, 16'd15, 8'd5, 1'b0);

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
